// File: rtl/reshape_pkg.sv
// Shared definitions for the reshape egress path: FSM state encoding and default widths.
package reshape_pkg;

  localparam int DEF_DATA_WIDTH     = 128;
  localparam int DEF_WIDTH_BEAT_NUM = 24;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/stream_skid_fifo.sv
// Two-entry skid buffer with registered outputs; push and pop may coincide at any occupancy.
module stream_skid_fifo
  import reshape_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_valid,
  output logic                  push_ready,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic                  pop_valid,
  input  logic                  pop_ready,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  full,
  output logic                  empty
);

  logic [1:0]            count_q, count_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  logic                  push_fire, pop_fire;

  always_comb begin
    count_d   = count_q;
    head_d    = head_q;
    tail_d    = tail_q;
    pop_fire  = (count_q != 2'd0) && pop_ready;
    push_fire = push_valid && ((count_q != 2'd2) || pop_fire);
    unique case ({push_fire, pop_fire})
      2'b10: begin
        if (count_q == 2'd0) head_d = push_data;
        else                 tail_d = push_data;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        // Occupancy unchanged: either replace the lone head or shift tail forward.
        if (count_q == 2'd1) begin
          head_d = push_data;
        end else begin
          head_d = tail_q;
          tail_d = push_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 2'd0;
      head_q  <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
    end
  end

  // The tail entry is only observable after it moves to the head, so it needs no reset.
  always_ff @(posedge clk) begin
    tail_q <= tail_d;
  end

  assign full       = (count_q == 2'd2);
  assign empty      = (count_q == 2'd0);
  assign push_ready = !full;
  assign pop_valid  = !empty;
  assign pop_data   = head_q;

endmodule

// File: rtl/reshape_write_stream.sv
// Egress stage of the reshape engine: counts a job's beats through a skid buffer to the DMA write channel.
module reshape_write_stream
  import reshape_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int WIDTH_BEAT_NUM = DEF_WIDTH_BEAT_NUM
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      Start,
  input  logic [WIDTH_BEAT_NUM-1:0] Beat_Num_REG,
  input  logic [DATA_WIDTH-1:0]     S_Data,
  input  logic                      S_Valid,
  output logic                      S_Ready,
  output logic [DATA_WIDTH-1:0]     M_Data,
  output logic                      M_Valid,
  input  logic                      M_Ready,
  output logic                      M_Last,
  output logic                      Busy,
  output logic                      Write_Complete,
  output logic [WIDTH_BEAT_NUM-1:0] Beat_Count
);

  localparam logic [WIDTH_BEAT_NUM-1:0] CNT_ONE = WIDTH_BEAT_NUM'(1);

  state_e                    state_q, state_d;
  logic [WIDTH_BEAT_NUM-1:0] total_q, total_d;
  logic [WIDTH_BEAT_NUM-1:0] in_cnt_q, in_cnt_d;
  logic [WIDTH_BEAT_NUM-1:0] out_cnt_q, out_cnt_d;

  logic fifo_full, fifo_empty, fifo_push_ready, fifo_push_valid, fifo_pop_valid;
  logic s_ready, s_fire, m_fire, last_out;

  // in_cnt never passes total, so surplus upstream beats wait for the next job.
  assign s_ready         = (state_q == RUN) && !fifo_full && (in_cnt_q != total_q);
  assign s_fire          = S_Valid && s_ready;
  assign fifo_push_valid = s_fire && fifo_push_ready;
  assign m_fire          = fifo_pop_valid && M_Ready;
  assign last_out        = (out_cnt_q == total_q - CNT_ONE);

  stream_skid_fifo #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push_valid(fifo_push_valid),
    .push_ready(fifo_push_ready),
    .push_data (S_Data),
    .pop_valid (fifo_pop_valid),
    .pop_ready (M_Ready),
    .pop_data  (M_Data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_d   = state_q;
    total_d   = total_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (Start) begin
          total_d   = Beat_Num_REG;
          in_cnt_d  = '0;
          out_cnt_d = '0;
          state_d   = (Beat_Num_REG == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (s_fire) in_cnt_d = in_cnt_q + CNT_ONE;
        if (m_fire) begin
          out_cnt_d = out_cnt_q + CNT_ONE;
          if (last_out) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      total_q   <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      total_q   <= total_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
    end
  end

  // Busy covers the accepting Start cycle as well as RUN and DONE.
  assign S_Ready        = s_ready;
  assign M_Valid        = fifo_pop_valid;
  assign M_Last         = !fifo_empty && last_out;
  assign Busy           = (state_q != IDLE) || Start;
  assign Write_Complete = (state_q == DONE);
  assign Beat_Count     = out_cnt_q;

endmodule

// File: tb/tb_reshape_write_stream.sv
// Directed bench for reshape_write_stream: queue-based job model checked every cycle plus literal job checks.
module tb_reshape_write_stream;

  localparam int DW = 128;
  localparam int BW = 24;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          Start = 1'b0;
  logic [BW-1:0] Beat_Num_REG = '0;
  logic [DW-1:0] S_Data = '0;
  logic          S_Valid = 1'b0;
  logic          M_Ready = 1'b0;
  logic          S_Ready, M_Valid, M_Last, Busy, Write_Complete;
  logic [DW-1:0] M_Data;
  logic [BW-1:0] Beat_Count;

  reshape_write_stream #(.DATA_WIDTH(DW), .WIDTH_BEAT_NUM(BW)) dut (
    .clk(clk), .rst(rst), .Start(Start), .Beat_Num_REG(Beat_Num_REG),
    .S_Data(S_Data), .S_Valid(S_Valid), .S_Ready(S_Ready),
    .M_Data(M_Data), .M_Valid(M_Valid), .M_Ready(M_Ready), .M_Last(M_Last),
    .Busy(Busy), .Write_Complete(Write_Complete), .Beat_Count(Beat_Count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Source and sink stimulus state
  int            src_idx = 0, src_limit = 0, cyc = 0, mr_len = 1;
  logic [DW-1:0] src_base = '0;
  logic          mr_pat [4];

  // Job model: phase 0=idle 1=running 2=complete; beats in flight = acc - del
  int            m_phase = 0, m_total = 0, m_acc = 0, m_del = 0, m_cnt = 0;
  logic [DW-1:0] exp_q[$];
  bit            chk_en = 0, prev_stall = 0;
  logic [DW-1:0] prev_data = '0;

  // Observed statistics, read as deltas by the directed checks
  int ncyc = 0, wc_cnt = 0, wc_cyc = 0, busy_cnt = 0, mvalid_cnt = 0, sready_cnt = 0;
  int mbeat_cnt = 0, mlast_cnt = 0, full_block_cnt = 0;
  int hs_cyc[$];

  function automatic logic [DW-1:0] beat_val(int k);
    return src_base + DW'(k);
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic compare_and_step();
    int occ;
    bit e_sready, e_mvalid, e_mlast, e_busy, e_wc, ok, s_hs, m_hs;
    logic [DW-1:0] e_data;
    occ      = m_acc - m_del;
    e_sready = (m_phase == 1) && (occ < 2) && (m_acc < m_total);
    e_mvalid = (occ > 0);
    e_data   = e_mvalid ? exp_q[0] : '0;
    e_mlast  = e_mvalid && (m_del == m_total - 1);
    e_busy   = (m_phase != 0) || Start;
    e_wc     = (m_phase == 2);
    ok = (S_Ready === e_sready) && (M_Valid === e_mvalid) && (M_Last === e_mlast) &&
         (Busy === e_busy) && (Write_Complete === e_wc) && (Beat_Count === BW'(m_cnt));
    if (e_mvalid && (M_Data !== e_data)) ok = 0;
    if (prev_stall && !((M_Valid === 1'b1) && (M_Data === prev_data))) ok = 0;
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL cycle %0d: got sr=%b mv=%b ml=%b busy=%b wc=%b bc=%0d data=%h, required sr=%b mv=%b ml=%b busy=%b wc=%b bc=%0d data=%h",
               ncyc, S_Ready, M_Valid, M_Last, Busy, Write_Complete, Beat_Count, M_Data,
               e_sready, e_mvalid, e_mlast, e_busy, e_wc, m_cnt, e_data);
    end
    if (M_Valid && M_Ready) begin
      mbeat_cnt++;
      hs_cyc.push_back(ncyc);
      if (M_Last) mlast_cnt++;
    end
    if (Write_Complete) begin
      wc_cnt++;
      wc_cyc = ncyc;
    end
    if (Busy) busy_cnt++;
    if (M_Valid) mvalid_cnt++;
    if (S_Ready) sready_cnt++;
    if ((occ == 2) && (S_Ready === 1'b0) && S_Valid) full_block_cnt++;
    prev_stall = M_Valid && !M_Ready;
    prev_data  = M_Data;
    ncyc++;
    if (rst) begin
      m_phase = 0; m_total = 0; m_acc = 0; m_del = 0; m_cnt = 0;
      exp_q.delete();
      prev_stall = 0;
    end else begin
      case (m_phase)
        0: if (Start) begin
          m_total = int'(Beat_Num_REG);
          m_acc = 0; m_del = 0; m_cnt = 0;
          m_phase = (m_total == 0) ? 2 : 1;
        end
        1: begin
          s_hs = S_Valid && e_sready;
          m_hs = e_mvalid && M_Ready;
          if (m_hs) begin
            void'(exp_q.pop_front());
            m_del++;
            m_cnt++;
          end
          if (s_hs) begin
            exp_q.push_back(S_Data);
            m_acc++;
          end
          if (m_hs && (m_del == m_total)) m_phase = 2;
        end
        default: m_phase = 0;
      endcase
    end
  endtask

  task automatic cycle();
    bit hs;
    @(negedge clk);
    hs = S_Valid && S_Ready;
    if (chk_en) compare_and_step();
    @(posedge clk);
    #1;
    Start = 1'b0;
    if (hs) src_idx++;
    S_Valid = (src_idx < src_limit);
    S_Data  = beat_val(src_idx);
    cyc++;
    M_Ready = mr_pat[cyc % mr_len];
  endtask

  task automatic set_source(logic [DW-1:0] base, int n);
    src_base  = base;
    src_idx   = 0;
    src_limit = n;
    S_Valid   = (n > 0);
    S_Data    = beat_val(0);
  endtask

  task automatic start_job(int n);
    Beat_Num_REG = BW'(n);
    Start = 1'b1;
    cycle();
  endtask

  task automatic wait_wc(string name, int budget);
    int w0, k;
    w0 = wc_cnt;
    k = 0;
    while ((wc_cnt == w0) && (k < budget)) begin
      cycle();
      k++;
    end
    check(name, 64'(wc_cnt - w0), 64'd1);
    cycle();
  endtask

  initial begin
    int b0, h0, l0, w0, bz0, mv0, sr0, k;
    mr_pat[0] = 1'b1; mr_pat[1] = 1'b1; mr_pat[2] = 1'b1; mr_pat[3] = 1'b1;
    mr_len = 1;
    M_Ready = 1'b1;
    repeat (2) cycle();
    chk_en = 1;
    rst = 1'b0;
    check("reset_mvalid", 64'(M_Valid), 64'd0);
    check("reset_mdata_zero", 64'(|M_Data), 64'd0);
    check("reset_sready", 64'(S_Ready), 64'd0);
    check("reset_busy", 64'(Busy), 64'd0);
    check("reset_beat_count", 64'(Beat_Count), 64'd0);
    cycle();

    // 1: four beats, sink always ready
    set_source(128'h1000, 4);
    b0 = mbeat_cnt; h0 = hs_cyc.size(); l0 = mlast_cnt;
    start_job(4);
    wait_wc("t1_wc", 30);
    check("t1_beats", 64'(mbeat_cnt - b0), 64'd4);
    if (mbeat_cnt - b0 == 4) begin
      check("t1_back_to_back", 64'(hs_cyc[h0+3] - hs_cyc[h0]), 64'd3);
      check("t1_wc_after_last", 64'(wc_cyc - hs_cyc[h0+3]), 64'd1);
    end
    check("t1_last_once", 64'(mlast_cnt - l0), 64'd1);
    check("t1_beat_count", 64'(Beat_Count), 64'd4);

    // 2: eight beats, sink ready pattern 1,0,0,1
    mr_pat[0] = 1'b1; mr_pat[1] = 1'b0; mr_pat[2] = 1'b0; mr_pat[3] = 1'b1;
    mr_len = 4;
    set_source(128'h2000, 8);
    b0 = mbeat_cnt; l0 = mlast_cnt; k = full_block_cnt;
    start_job(8);
    wait_wc("t2_wc", 80);
    check("t2_beats", 64'(mbeat_cnt - b0), 64'd8);
    check("t2_last_once", 64'(mlast_cnt - l0), 64'd1);
    check("t2_full_blocks_input", 64'(full_block_cnt > k), 64'd1);
    check("t2_beat_count", 64'(Beat_Count), 64'd8);

    // 3: three-beat job with five beats offered; the surplus waits for the next job
    mr_len = 1; mr_pat[0] = 1'b1;
    set_source(128'h3000, 5);
    start_job(3);
    wait_wc("t3a_wc", 30);
    repeat (3) cycle();
    check("t3_accepted_first", 64'(src_idx), 64'd3);
    check("t3_sready_idle", 64'(S_Ready), 64'd0);
    start_job(2);
    wait_wc("t3b_wc", 30);
    check("t3_accepted_total", 64'(src_idx), 64'd5);
    check("t3_beat_count", 64'(Beat_Count), 64'd2);

    // 4: empty job
    set_source(128'h4000, 1);
    bz0 = busy_cnt; mv0 = mvalid_cnt; sr0 = sready_cnt; w0 = wc_cnt;
    start_job(0);
    wait_wc("t4_wc", 10);
    repeat (2) cycle();
    check("t4_busy_cycles", 64'(busy_cnt - bz0), 64'd2);
    check("t4_wc_pulses", 64'(wc_cnt - w0), 64'd1);
    check("t4_no_mvalid", 64'(mvalid_cnt - mv0), 64'd0);
    check("t4_no_sready", 64'(sready_cnt - sr0), 64'd0);
    check("t4_beat_count", 64'(Beat_Count), 64'd0);

    // 5: reset after two of six beats delivered
    set_source(128'h5000, 6);
    start_job(6);
    k = 0;
    while ((Beat_Count != BW'(2)) && (k < 40)) begin
      cycle();
      k++;
    end
    check("t5_reached_two", 64'(Beat_Count), 64'd2);
    w0 = wc_cnt;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("t5_mvalid", 64'(M_Valid), 64'd0);
    check("t5_mdata_zero", 64'(|M_Data), 64'd0);
    check("t5_mlast", 64'(M_Last), 64'd0);
    check("t5_sready", 64'(S_Ready), 64'd0);
    check("t5_busy", 64'(Busy), 64'd0);
    check("t5_wc", 64'(Write_Complete), 64'd0);
    check("t5_beat_count", 64'(Beat_Count), 64'd0);
    repeat (5) cycle();
    check("t5_no_wc_after_abort", 64'(wc_cnt - w0), 64'd0);
    set_source(128'h5100, 2);
    b0 = mbeat_cnt;
    start_job(2);
    wait_wc("t5b_wc", 30);
    check("t5b_beats", 64'(mbeat_cnt - b0), 64'd2);
    check("t5b_beat_count", 64'(Beat_Count), 64'd2);

    // 6: second Start during RUN is ignored
    mr_pat[0] = 1'b1; mr_pat[1] = 1'b0;
    mr_len = 2;
    set_source(128'h6000, 5);
    b0 = mbeat_cnt; w0 = wc_cnt;
    start_job(5);
    repeat (2) cycle();
    Beat_Num_REG = BW'(9);
    Start = 1'b1;
    cycle();
    wait_wc("t6_wc", 60);
    repeat (3) cycle();
    check("t6_beats", 64'(mbeat_cnt - b0), 64'd5);
    check("t6_wc_pulses", 64'(wc_cnt - w0), 64'd1);
    check("t6_beat_count", 64'(Beat_Count), 64'd5);
    check("t6_accepted", 64'(src_idx), 64'd5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reshape_write_stream.md
Name: reshape_write_stream

Overview:
- Output stage directly downstream of the reshape engine's merged stream (M_Data/M_Valid/M_Ready). It feeds the DMA write channel.
- For each reshape job it counts a programmed number of output beats and passes them through a 2-deep skid buffer.
- It asserts M_Last on the final beat and pulses Write_Complete once the DMA has accepted that beat.
- Upstream stalls never corrupt data. The DMA sees registered valid/data.

Parameters:
- DATA_WIDTH, 128, stream beat width (matches AXI_WIDTH_DATA_IN).
- WIDTH_BEAT_NUM, 24, width of the beat-count register and counters.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- Start  in  1  one-cycle pulse; latches Beat_Num_REG and begins a job.
- Beat_Num_REG  in  WIDTH_BEAT_NUM  number of beats in the job.
- S_Data  in  DATA_WIDTH  input beat from the reshape output stream.
- S_Valid  in  1  input valid.
- S_Ready  out  1  input ready.
- M_Data  out  DATA_WIDTH  beat to the DMA write channel.
- M_Valid  out  1  output valid.
- M_Ready  in  1  DMA ready.
- M_Last  out  1  high together with M_Valid on the final beat of the job.
- Busy  out  1  high from the accepted Start until the Write_Complete cycle, inclusive.
- Write_Complete  out  1  one-cycle pulse after the last beat handshakes on M.
- Beat_Count  out  WIDTH_BEAT_NUM  beats delivered on M in the current job.

Behaviour:
- Reset: every output is 0, FSM is IDLE, FIFO is empty, counters are 0.
- rst asserted mid-job aborts the job immediately. Buffered beats are discarded and no Write_Complete is produced.
- FSM states: IDLE, RUN, DONE.
  - IDLE: Start latches total = Beat_Num_REG and clears both counters.
    - total == 0: go to DONE.
    - total != 0: go to RUN.
    - Start received in RUN or DONE is ignored.
  - RUN: in_cnt counts S handshakes, where an S handshake is S_Valid && S_Ready.
    - out_cnt counts M handshakes, where an M handshake is M_Valid && M_Ready.
    - Go to DONE in the cycle after the M handshake with out_cnt == total-1.
  - DONE: Write_Complete = 1 for exactly one cycle, Busy = 1, then go to IDLE.
- S_Ready = (state == RUN) && !fifo_full && (in_cnt != total).
  - Beats beyond total are never accepted; they stay pending upstream for the next job.
- Skid FIFO:
  - 2 entries; outputs come directly from registers.
  - M_Valid = !fifo_empty.
  - M_Data = head entry.
  - Push and pop in the same cycle is legal at any occupancy, including full; occupancy is then unchanged.
  - Zero-bubble throughput: 1 beat/clk when M_Ready is held high.
- Latency: a beat accepted on S in cycle n is presented on M in cycle n+1 at the earliest.
- M_Last = M_Valid && (out_cnt == total-1).
  - It is held stable with the data while M_Ready is low.
- Beat_Count = out_cnt.
  - It increments on each M handshake.
  - It holds its value through DONE and IDLE until the next accepted Start.
- M_Valid/M_Data must not change while M_Valid = 1 and M_Ready = 0, as AXI-Stream requires.
- Counter arithmetic is unsigned, WIDTH_BEAT_NUM bits.
  - total = 2^WIDTH_BEAT_NUM-1 is legal.
  - Counters never wrap within a job.
- Start and the last M handshake in the same cycle: the FSM is not IDLE, so Start is ignored.

Decomposition:
- Shared package (reshape_pkg) holds:
  - the state encoding constants: IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - default DATA_WIDTH and WIDTH_BEAT_NUM.
- One sub-module: stream_skid_fifo.
  - Parameter DATA_WIDTH, depth fixed at 2.
  - Ports: push valid/ready/data and pop valid/ready/data, plus full and empty.
  - Reused for the other reshape egress paths.
- Top level holds the FSM, the counters and the M_Last compare.

Test Plan:
1. Start with Beat_Num_REG=4, 4 beats on S, M_Ready tied 1 -> 4 M beats in 4 consecutive cycles, M_Last only on beat 4, Write_Complete 1 cycle later, Beat_Count=4.
2. Beat_Num_REG=8, S_Valid always 1, M_Ready toggling 1,0,0,1 -> no beat lost or duplicated, data order preserved, M_Data stable while stalled, S_Ready=0 when the FIFO holds 2.
3. Beat_Num_REG=3 with 5 beats offered on S -> exactly 3 accepted, S_Ready=0 after the third, the remaining 2 are accepted only after a new Start.
4. Beat_Num_REG=0 -> Busy for 2 cycles, Write_Complete pulse, no M_Valid, S_Ready never 1.
5. rst asserted after 2 of 6 beats are delivered -> next cycle all outputs are 0 and there is no Write_Complete; a following job with Beat_Num_REG=2 completes normally.
6. Start pulsed again during RUN -> ignored; total and counters unchanged; the job completes on the original count.
